branch_predictor: RTL and testbench

Parametrised branch target buffer with per-entry saturating direction counters for the 5-stage pipelined RISC-V core. It predicts the next fetch PC in IF and is trained by resolved branches/jumps in EX. It also produces the EX-stage mispredict/redirect signals that drive the PC mux and the hazard unit's flush logic, replacing the fixed "predict not-taken, flush on PCSrcE" scheme. Statistics counters are included for performance measurement.

---
 rtl/branch_predictor.sv | 140 ++++++++++++++
 tb/tb_branch_predictor.sv | 138 +++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Branch target buffer with per-entry saturating direction counters.
// Predicts the next fetch PC in IF, trains from resolved control flow in EX and flags EX mispredicts.
module branch_predictor #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16,
    parameter int CTR_W   = 2,
    parameter int STAT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              PredEnable,
    input  logic [XLEN-1:0]   PCF,
    output logic              PredTakenF,
    output logic [XLEN-1:0]   NextPCPredF,
    input  logic              ValidE,
    input  logic              CtrlE,
    input  logic              IsJumpE,
    input  logic              TakenE,
    input  logic [XLEN-1:0]   PCE,
    input  logic [XLEN-1:0]   TargetE,
    input  logic [XLEN-1:0]   PCPlus4E,
    input  logic              PredTakenE,
    input  logic [XLEN-1:0]   PredTargetE,
    output logic              MispredictE,
    output logic [XLEN-1:0]   RedirectPCE,
    output logic [STAT_W-1:0] BranchCount,
    output logic [STAT_W-1:0] MispredictCount
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;
    localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(1) << (CTR_W - 1);

    logic              valid_q  [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [XLEN-1:0]   target_q [ENTRIES];
    logic [CTR_W-1:0]  ctr_q    [ENTRIES];
    logic              jump_q   [ENTRIES];
    logic [STAT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [STAT_W-1:0] mis_cnt_q, mis_cnt_d;

    logic [IDX_W-1:0]  idx_f_s, idx_e_s;
    logic [TAG_W-1:0]  tag_f_s, tag_e_s;
    logic              hit_f_s, hit_e_s, actual_taken_s;
    logic              wr_en_s, wr_valid_d, wr_jump_d;
    logic [XLEN-1:0]   wr_target_d;
    logic [CTR_W-1:0]  wr_ctr_d;
    logic              unused_s;

    assign idx_f_s = PCF[IDX_W+1:2];
    assign tag_f_s = PCF[XLEN-1:IDX_W+2];
    assign idx_e_s = PCE[IDX_W+1:2];
    assign tag_e_s = PCE[XLEN-1:IDX_W+2];
    assign hit_f_s = valid_q[idx_f_s] && (tag_q[idx_f_s] == tag_f_s);
    assign hit_e_s = valid_q[idx_e_s] && (tag_q[idx_e_s] == tag_e_s);
    assign unused_s = ^{PCF[1:0], PCE[1:0]};

    assign PredTakenF     = PredEnable && hit_f_s && (jump_q[idx_f_s] || ctr_q[idx_f_s][CTR_W-1]);
    assign NextPCPredF    = PredTakenF ? target_q[idx_f_s] : (PCF + XLEN'(4));
    assign actual_taken_s = CtrlE && TakenE;
    assign RedirectPCE    = actual_taken_s ? TargetE : PCPlus4E;
    // A taken prediction with the wrong target is also a mispredict.
    assign MispredictE    = ValidE && ((PredTakenE != actual_taken_s) ||
                            (actual_taken_s && PredTakenE && (PredTargetE != TargetE)));
    assign BranchCount     = branch_cnt_q;
    assign MispredictCount = mis_cnt_q;

    // Next state of the EX-indexed entry and of the statistics counters.
    always_comb begin
        wr_en_s     = 1'b0;
        wr_valid_d  = valid_q[idx_e_s];
        wr_ctr_d    = ctr_q[idx_e_s];
        wr_target_d = target_q[idx_e_s];
        wr_jump_d   = jump_q[idx_e_s];
        if (ValidE && CtrlE) begin
            if (hit_e_s) begin
                wr_en_s   = 1'b1;
                wr_jump_d = IsJumpE;
                if (TakenE) begin
                    wr_target_d = TargetE;
                    wr_ctr_d    = (ctr_q[idx_e_s] == CTR_MAX) ? CTR_MAX : ctr_q[idx_e_s] + CTR_W'(1);
                end else begin
                    wr_ctr_d    = (ctr_q[idx_e_s] == '0) ? '0 : ctr_q[idx_e_s] - CTR_W'(1);
                end
            end else if (TakenE) begin
                wr_en_s     = 1'b1;
                wr_valid_d  = 1'b1;
                wr_target_d = TargetE;
                wr_ctr_d    = CTR_WEAK;
                wr_jump_d   = IsJumpE;
            end else begin
                wr_en_s = 1'b0;
            end
        end else if (ValidE && PredTakenE && hit_e_s) begin
            // Non-control instruction predicted taken: drop the stale entry.
            wr_en_s    = 1'b1;
            wr_valid_d = 1'b0;
        end else begin
            wr_en_s = 1'b0;
        end

        branch_cnt_d = branch_cnt_q;
        if (ValidE && CtrlE && (branch_cnt_q != {STAT_W{1'b1}})) begin
            branch_cnt_d = branch_cnt_q + STAT_W'(1);
        end else begin
            branch_cnt_d = branch_cnt_q;
        end
        mis_cnt_d = mis_cnt_q;
        if (MispredictE && (mis_cnt_q != {STAT_W{1'b1}})) begin
            mis_cnt_d = mis_cnt_q + STAT_W'(1);
        end else begin
            mis_cnt_d = mis_cnt_q;
        end
    end

    // BTB storage and statistics registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= '0;
                jump_q[i]   <= 1'b0;
            end
            branch_cnt_q <= '0;
            mis_cnt_q    <= '0;
        end else begin
            if (wr_en_s) begin
                valid_q[idx_e_s]  <= wr_valid_d;
                tag_q[idx_e_s]    <= tag_e_s;
                target_q[idx_e_s] <= wr_target_d;
                ctr_q[idx_e_s]    <= wr_ctr_d;
                jump_q[idx_e_s]   <= wr_jump_d;
            end
            branch_cnt_q <= branch_cnt_d;
            mis_cnt_q    <= mis_cnt_d;
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// Directed, table-driven bench for branch_predictor (default parameters).
module tb_branch_predictor;
    logic        clk = 1'b0;
    logic        reset, PredEnable, ValidE, CtrlE, IsJumpE, TakenE, PredTakenE;
    logic [31:0] PCF, PCE, TargetE, PCPlus4E, PredTargetE;
    logic        PredTakenF, MispredictE;
    logic [31:0] NextPCPredF, RedirectPCE, BranchCount, MispredictCount;
    int          n_cmp = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    branch_predictor dut (
        .clk(clk), .reset(reset), .PredEnable(PredEnable), .PCF(PCF),
        .PredTakenF(PredTakenF), .NextPCPredF(NextPCPredF),
        .ValidE(ValidE), .CtrlE(CtrlE), .IsJumpE(IsJumpE), .TakenE(TakenE),
        .PCE(PCE), .TargetE(TargetE), .PCPlus4E(PCPlus4E),
        .PredTakenE(PredTakenE), .PredTargetE(PredTargetE),
        .MispredictE(MispredictE), .RedirectPCE(RedirectPCE),
        .BranchCount(BranchCount), .MispredictCount(MispredictCount)
    );

    typedef struct {
        logic        pe;
        logic [31:0] pcf;
        logic        v, c, j, t;
        logic [31:0] pce, tgt;
        logic        pt;
        logic [31:0] ptg;
        logic        e_pf;
        logic [31:0] e_np;
        logic        e_mis;
        logic [31:0] e_red, e_bc, e_mc;
    } vec_t;

    vec_t vecs[24];

    function automatic vec_t mk(logic pe, logic [31:0] pcf, logic v, logic c, logic j, logic t,
                                logic [31:0] pce, logic [31:0] tgt, logic pt, logic [31:0] ptg,
                                logic e_pf, logic [31:0] e_np, logic e_mis, logic [31:0] e_red,
                                logic [31:0] e_bc, logic [31:0] e_mc);
        vec_t r;
        r.pe = pe; r.pcf = pcf; r.v = v; r.c = c; r.j = j; r.t = t;
        r.pce = pce; r.tgt = tgt; r.pt = pt; r.ptg = ptg;
        r.e_pf = e_pf; r.e_np = e_np; r.e_mis = e_mis; r.e_red = e_red;
        r.e_bc = e_bc; r.e_mc = e_mc;
        return r;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(vec_t x);
        PredEnable = x.pe; PCF = x.pcf; ValidE = x.v; CtrlE = x.c; IsJumpE = x.j;
        TakenE = x.t; PCE = x.pce; TargetE = x.tgt; PCPlus4E = x.pce + 32'd4;
        PredTakenE = x.pt; PredTargetE = x.ptg;
    endtask

    task automatic check_vec(int k, vec_t x);
        chk($sformatf("v%0d PredTakenF", k), {31'd0, PredTakenF}, {31'd0, x.e_pf});
        chk($sformatf("v%0d NextPCPredF", k), NextPCPredF, x.e_np);
        chk($sformatf("v%0d MispredictE", k), {31'd0, MispredictE}, {31'd0, x.e_mis});
        chk($sformatf("v%0d RedirectPCE", k), RedirectPCE, x.e_red);
        chk($sformatf("v%0d BranchCount", k), BranchCount, x.e_bc);
        chk($sformatf("v%0d MispredictCount", k), MispredictCount, x.e_mc);
    endtask

    initial begin
        vec_t idle;
        // Cold allocate, counter walk 10->01->00->01->10->11 (held), alias, jump, invalidate.
        vecs[0]  = mk(1, 32'h100, 1, 1, 0, 1, 32'h100, 32'h80, 0, 32'h0,  0, 32'h104, 1, 32'h80,  0, 0);
        vecs[1]  = mk(1, 32'h100, 0, 0, 0, 0, 32'h0,   32'h0,  0, 32'h0,  1, 32'h80,  0, 32'h4,   1, 1);
        vecs[2]  = mk(1, 32'h100, 1, 1, 0, 0, 32'h100, 32'h80, 1, 32'h80, 1, 32'h80,  1, 32'h104, 1, 1);
        vecs[3]  = mk(1, 32'h100, 1, 1, 0, 0, 32'h100, 32'h80, 0, 32'h0,  0, 32'h104, 0, 32'h104, 2, 2);
        vecs[4]  = mk(1, 32'h100, 1, 1, 0, 1, 32'h100, 32'h80, 0, 32'h0,  0, 32'h104, 1, 32'h80,  3, 2);
        vecs[5]  = mk(1, 32'h100, 1, 1, 0, 1, 32'h100, 32'h80, 0, 32'h0,  0, 32'h104, 1, 32'h80,  4, 3);
        vecs[6]  = mk(1, 32'h100, 1, 1, 0, 1, 32'h100, 32'h80, 1, 32'h80, 1, 32'h80,  0, 32'h80,  5, 4);
        vecs[7]  = mk(1, 32'h100, 1, 1, 0, 1, 32'h100, 32'h80, 1, 32'h80, 1, 32'h80,  0, 32'h80,  6, 4);
        vecs[8]  = mk(1, 32'h100, 1, 1, 0, 0, 32'h100, 32'h80, 1, 32'h80, 1, 32'h80,  1, 32'h104, 7, 4);
        vecs[9]  = mk(1, 32'h100, 0, 0, 0, 0, 32'h0,   32'h0,  0, 32'h0,  1, 32'h80,  0, 32'h4,   8, 5);
        vecs[10] = mk(1, 32'h140, 0, 0, 0, 0, 32'h0,   32'h0,  0, 32'h0,  0, 32'h144, 0, 32'h4,   8, 5);
        vecs[11] = mk(1, 32'h140, 1, 1, 0, 1, 32'h140, 32'h300,0, 32'h0,  0, 32'h144, 1, 32'h300, 8, 5);
        vecs[12] = mk(1, 32'h100, 0, 0, 0, 0, 32'h0,   32'h0,  0, 32'h0,  0, 32'h104, 0, 32'h4,   9, 6);
        vecs[13] = mk(1, 32'h140, 0, 0, 0, 0, 32'h0,   32'h0,  0, 32'h0,  1, 32'h300, 0, 32'h4,   9, 6);
        vecs[14] = mk(1, 32'h200, 1, 1, 1, 1, 32'h200, 32'h40, 0, 32'h0,  0, 32'h204, 1, 32'h40,  9, 6);
        vecs[15] = mk(1, 32'h200, 0, 0, 0, 0, 32'h0,   32'h0,  0, 32'h0,  1, 32'h40,  0, 32'h4,   10, 7);
        vecs[16] = mk(1, 32'h200, 1, 1, 1, 1, 32'h200, 32'h40, 1, 32'h40, 1, 32'h40,  0, 32'h40,  10, 7);
        vecs[17] = mk(0, 32'h200, 0, 0, 0, 0, 32'h0,   32'h0,  0, 32'h0,  0, 32'h204, 0, 32'h4,   11, 7);
        vecs[18] = mk(1, 32'h200, 1, 0, 0, 0, 32'h200, 32'h0,  1, 32'h40, 1, 32'h40,  1, 32'h204, 11, 7);
        vecs[19] = mk(1, 32'h200, 0, 0, 0, 0, 32'h0,   32'h0,  0, 32'h0,  0, 32'h204, 0, 32'h4,   11, 8);
        vecs[20] = mk(1, 32'h104, 1, 1, 0, 1, 32'h104, 32'h500,1, 32'h400,0, 32'h108, 1, 32'h500, 11, 8);
        vecs[21] = mk(1, 32'h104, 0, 0, 0, 0, 32'h0,   32'h0,  0, 32'h0,  1, 32'h500, 0, 32'h4,   12, 9);
        vecs[22] = mk(1, 32'h104, 0, 1, 0, 1, 32'h104, 32'h600,0, 32'h0,  1, 32'h500, 0, 32'h600, 12, 9);
        vecs[23] = mk(1, 32'h104, 0, 0, 0, 0, 32'h0,   32'h0,  0, 32'h0,  1, 32'h500, 0, 32'h4,   12, 9);

        idle = mk(1, 32'h100, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 0, 32'h104, 0, 32'h4, 0, 0);
        drive(idle);
        reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_vec(-1, idle);
        @(posedge clk); #1;

        for (int k = 0; k < 24; k++) begin
            drive(vecs[k]);
            @(negedge clk);
            check_vec(k, vecs[k]);
            @(posedge clk); #1;
        end

        // Reset while a taken branch at 0x108 trains: nothing written, all state cleared.
        drive(mk(1, 32'h108, 1, 1, 0, 1, 32'h108, 32'h700, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 0));
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        idle.pcf = 32'h108; idle.e_np = 32'h10c;
        drive(idle);
        @(negedge clk);
        check_vec(100, idle);
        PCF = 32'h104;
        #1;
        chk("rst PredTakenF 0x104", {31'd0, PredTakenF}, 32'd0);
        chk("rst NextPCPredF 0x104", NextPCPredF, 32'h108);
        PCF = 32'h100;
        #1;
        chk("rst NextPCPredF 0x100", NextPCPredF, 32'h104);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
